md_unit: RTL and testbench

Multi-cycle multiply/divide controller for the five-stage pipeline. It sits beside the E-stage ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU operations and sequences each over a fixed number of cycles, asserting `busy` for the whole of that time. MTHI/MTLO writes complete in one cycle. The hazard unit uses `busy` to hold any HI/LO instruction in D until the result is committed.

---
 rtl/md_unit.sv | 144 ++++++++++++++
 tb/tb_md_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide controller owning the HI/LO pair.
// The arithmetic is evaluated once at the accepting edge and held in a
// pending register pair. HI/LO are committed only when the cycle counter
// expires, so software never sees an intermediate value.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_ph;
  logic [31:0]   r_pl;
  logic          r_div0;

  // Products: operands widened to 64 bits so the result width is explicit.
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  // Division datapath, evaluated on the current operands.
  logic        w_sgn;
  logic        w_b_zero;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes with an unsigned divider and the
  // signs restored afterwards. This truncates toward zero, gives the remainder
  // the sign of the dividend, and makes 0x80000000 / -1 wrap to 0x80000000
  // without any special case.
  always_comb begin
    w_sgn    = (op == OP_DIV);
    w_b_zero = (b == '0);
    w_dvd    = (w_sgn && a[31]) ? (~a + 32'd1) : a;
    w_dvs    = (w_sgn && b[31]) ? (~b + 32'd1) : b;
    w_q_mag  = '0;
    w_r_mag  = '0;
    if (!w_b_zero) begin
      w_q_mag = w_dvd / w_dvs;
      w_r_mag = w_dvd % w_dvs;
    end
    w_quot = (w_sgn && (a[31] ^ b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    w_rem  = (w_sgn && a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;
  end

  // Controller: accepts work in IDLE, counts down in MUL/DIV, commits on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ph    <= '0;
      r_pl    <= '0;
      r_div0  <= 1'b0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT: begin
                {r_ph, r_pl} <= w_prod_s;
                r_div0       <= 1'b0;
                r_cnt        <= CW'(MULT_CYCLES);
                r_state      <= S_MUL;
                busy         <= 1'b1;
              end
              OP_MULTU: begin
                {r_ph, r_pl} <= w_prod_u;
                r_div0       <= 1'b0;
                r_cnt        <= CW'(MULT_CYCLES);
                r_state      <= S_MUL;
                busy         <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                r_pl    <= w_quot;
                r_ph    <= w_rem;
                r_div0  <= w_b_zero;
                r_cnt   <= CW'(DIV_CYCLES);
                r_state <= S_DIV;
                busy    <= 1'b1;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            // A zero divisor still burns the full latency but leaves HI/LO intact.
            if (!r_div0) begin
              hi <= r_ph;
              lo <= r_pl;
            end
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit. Stimulus pushes the expected
// HI/LO and busy length; a monitor pops on each completed operation.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  logic mon_prev_busy = 1'b0;
  int   busy_cnt      = 0;
  logic mt_pend       = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input int cyc);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_result: got hi=%h lo=%h want no result at %0t", hi, lo, $time);
    end else begin
      e = q.pop_front();
      chk("hi", hi, e.hi);
      chk("lo", lo, e.lo);
      if (e.cyc == 0) chk("mt_busy", {31'd0, busy}, 32'd0);
      else            chk("busy_cycles", cyc, e.cyc);
    end
  endtask

  // Monitor, input side: spot accepted MTHI/MTLO and protocol violations.
  always @(posedge clk) begin
    if (reset === 1'b1 && start === 1'b1) begin
      if (busy === 1'b1)
        $display("protocol: start op=%0d issued while busy at %0t (must be ignored)", op, $time);
      else if (op == 3'd4 || op == 3'd5)
        mt_pend = 1'b1;
    end
  end

  // Monitor, output side: compare on MT completion or busy falling.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mt_pend) begin
        mt_pend = 1'b0;
        pop_cmp(0);
      end
      if (busy === 1'b1) busy_cnt++;
      else if (mon_prev_busy) begin
        pop_cmp(busy_cnt);
        busy_cnt = 0;
      end
      mon_prev_busy = busy;
    end
  end

  // An aborted operation produces no result.
  always @(negedge reset) begin
    mon_prev_busy = 1'b0;
    busy_cnt      = 0;
    mt_pend       = 1'b0;
  end

  task automatic push(input logic [31:0] eh, input logic [31:0] el, input int ec);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.cyc = ec;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL busy_timeout: got busy=%b want 0 within 200 cycles", busy);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] eh, input logic [31:0] el, input int ec);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = xa;
    b     = xb;
    push(eh, el, ec);
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    if (ec > 0) wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_hi", hi, 32'd0);
      chk("idle_lo", lo, 32'd0);
    end

    issue(3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, MC);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3,          32'h0000_0002, 32'hFFFF_FFFA, MC);
    issue(3'd0, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, MC);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, DC);
    issue(3'd3, 32'd7,         32'd2,          32'h0000_0001, 32'h0000_0003, DC);
    issue(3'd2, 32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, DC);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, DC);
    issue(3'd3, 32'hFFFF_FFFF, 32'h10,         32'h0000_000F, 32'h0FFF_FFFF, DC);
    issue(3'd4, 32'h1234,      32'd0,          32'h0000_1234, 32'h0FFF_FFFF, 0);
    issue(3'd5, 32'h5678,      32'd0,          32'h0000_1234, 32'h0000_5678, 0);
    issue(3'd2, 32'd5,         32'd0,          32'h0000_1234, 32'h0000_5678, DC);
    issue(3'd3, 32'd9,         32'd0,          32'h0000_1234, 32'h0000_5678, DC);

    // Reserved opcode: no visible effect and no busy.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd6;
    a     = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("rsvd_busy", {31'd0, busy}, 32'd0);
    chk("rsvd_hi", hi, 32'h1234);
    chk("rsvd_lo", lo, 32'h5678);

    // MULTU followed by an MTLO held through busy, then accepted at once.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd1;
    a     = 32'h0001_0000;
    b     = 32'h0001_0000;
    push(32'h1, 32'h0, MC);
    @(negedge clk);
    op = 3'd5;
    a  = 32'hDEAD;
    b  = 32'hBEEF;
    wait_idle();
    a = 32'hAA;
    push(32'h1, 32'hAA, 0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the fourth busy cycle of a DIV.
    start = 1'b1;
    op    = 3'd2;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("post_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);

    repeat (3) @(negedge clk);
    chk("queue_left", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
